// File: rtl/mmcm_lock_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mmcm_lock_pkg
//  Description : Shared types and helpers for the MMCM lock controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package mmcm_lock_pkg;

    // Controller states, explicitly 3 bits wide.
    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        WAIT   = 3'd1,
        STABLE = 3'd2,
        RUN    = 3'd3,
        FAULT  = 3'd4
    } lock_state_t;

    // Counter width for a count limit; never less than one bit.
    function automatic int cnt_width(input int limit);
        return (limit <= 1) ? 1 : $clog2(limit);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mmcm_lock_ctrl_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Two-flop synchronizer for asynchronous status inputs.
//                Both stages reset to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] meta_d;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync_d;

    // Next values: first stage captures the async input, second stage resolves it.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer register chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule
`default_nettype wire

// File: rtl/mmcm_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mmcm_lock_ctrl
//  Description : Drives the MMCM reset, watches its LOCKED output and releases
//                the downstream reset once lock has been stable long enough.
//                Retries on timeout, faults after MAX_RETRIES failures.
//  Options     : MMCM_LOCK_CTRL_RELOCK_CNT_EN - adds relock_cnt output that
//                counts RUN->HOLD lock-loss events (saturating, rst-only clear).
//  Revision    : 1.0 - initial release
// ============================================================================
module mmcm_lock_ctrl
    import mmcm_lock_pkg::*;
#(
    parameter int RST_CYCLES    = 8,
    parameter int LOCK_TIMEOUT  = 100000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4
) (
    input  logic                               clk_100m,
    input  logic                               rst,
    input  logic                               locked,
    output logic                               mmcm_rst,
    output logic                               sys_rst,
    output logic                               ready,
    output logic                               fault,
`ifdef MMCM_LOCK_CTRL_RELOCK_CNT_EN
    output logic [15:0]                        relock_cnt,
`endif
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retries
);

    localparam int HOLD_W   = cnt_width(RST_CYCLES);
    localparam int WAIT_W   = cnt_width(LOCK_TIMEOUT);
    localparam int STABLE_W = cnt_width(STABLE_CYCLES);
    localparam int RET_W    = $clog2(MAX_RETRIES + 1);

    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(RST_CYCLES - 1);
    localparam logic [WAIT_W-1:0]   WAIT_LAST   = WAIT_W'(LOCK_TIMEOUT - 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(STABLE_CYCLES - 1);
    localparam logic [RET_W-1:0]    RET_LAST    = RET_W'(MAX_RETRIES - 1);
    localparam logic [RET_W-1:0]    RET_MAX     = RET_W'(MAX_RETRIES);

    logic locked_s;

    lock_state_t         state_q,      state_d;
    logic [HOLD_W-1:0]   hold_cnt_q,   hold_cnt_d;
    logic [WAIT_W-1:0]   wait_tmr_q,   wait_tmr_d;
    logic [STABLE_W-1:0] stable_cnt_q, stable_cnt_d;
    logic [RET_W-1:0]    retries_q,    retries_d;
    logic                mmcm_rst_q,   mmcm_rst_d;
    logic                sys_rst_q,    sys_rst_d;
    logic                ready_q,      ready_d;
    logic                fault_q,      fault_d;
    logic                fail;
`ifdef MMCM_LOCK_CTRL_RELOCK_CNT_EN
    logic [15:0]         relock_cnt_q, relock_cnt_d;
`endif

    sync_2ff #(
        .WIDTH (1)
    ) u_lock_sync (
        .clk (clk_100m),
        .rst (rst),
        .d   (locked),
        .q   (locked_s)
    );

    // Next-state, counter and output decode; outputs follow the next state so
    // they change on the same edge as the state register.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        wait_tmr_d   = wait_tmr_q;
        stable_cnt_d = stable_cnt_q;
        retries_d    = retries_q;
        fail         = 1'b0;
`ifdef MMCM_LOCK_CTRL_RELOCK_CNT_EN
        relock_cnt_d = relock_cnt_q;
`endif

        case (state_q)
            HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    state_d = WAIT;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            WAIT: begin
                // Lock wins over a timeout landing in the same cycle.
                if (locked_s) begin
                    state_d = STABLE;
                end else if (wait_tmr_q == WAIT_LAST) begin
                    fail = 1'b1;
                end else begin
                    wait_tmr_d = wait_tmr_q + 1'b1;
                end
            end
            STABLE: begin
                // A dropout here is a glitch: re-wait without counting a failure.
                if (!locked_s) begin
                    state_d = WAIT;
                end else if (stable_cnt_q == STABLE_LAST) begin
                    state_d   = RUN;
                    retries_d = '0;
                end else begin
                    stable_cnt_d = stable_cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d = HOLD;
`ifdef MMCM_LOCK_CTRL_RELOCK_CNT_EN
                    if (relock_cnt_q != 16'hFFFF) begin
                        relock_cnt_d = relock_cnt_q + 16'd1;
                    end
`endif
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = HOLD;
            end
        endcase

        if (fail) begin
            if (retries_q == RET_LAST) begin
                retries_d = RET_MAX;
                state_d   = FAULT;
            end else begin
                retries_d = retries_q + 1'b1;
                state_d   = HOLD;
            end
        end

        // Every state entry starts all counters from zero.
        if (state_d != state_q) begin
            hold_cnt_d   = '0;
            wait_tmr_d   = '0;
            stable_cnt_d = '0;
        end

        mmcm_rst_d = (state_d == HOLD) || (state_d == FAULT);
        sys_rst_d  = (state_d != RUN);
        ready_d    = (state_d == RUN);
        fault_d    = (state_d == FAULT);
    end

    // State, counter and output registers with synchronous reset.
    always_ff @(posedge clk_100m) begin
        if (rst) begin
            state_q      <= HOLD;
            hold_cnt_q   <= '0;
            wait_tmr_q   <= '0;
            stable_cnt_q <= '0;
            retries_q    <= '0;
            mmcm_rst_q   <= 1'b1;
            sys_rst_q    <= 1'b1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
`ifdef MMCM_LOCK_CTRL_RELOCK_CNT_EN
            relock_cnt_q <= '0;
`endif
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            wait_tmr_q   <= wait_tmr_d;
            stable_cnt_q <= stable_cnt_d;
            retries_q    <= retries_d;
            mmcm_rst_q   <= mmcm_rst_d;
            sys_rst_q    <= sys_rst_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
`ifdef MMCM_LOCK_CTRL_RELOCK_CNT_EN
            relock_cnt_q <= relock_cnt_d;
`endif
        end
    end

    assign mmcm_rst = mmcm_rst_q;
    assign sys_rst  = sys_rst_q;
    assign ready    = ready_q;
    assign fault    = fault_q;
    assign retries  = retries_q;
`ifdef MMCM_LOCK_CTRL_RELOCK_CNT_EN
    assign relock_cnt = relock_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mmcm_lock_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mmcm_lock_ctrl
//  Description : Scoreboard bench for mmcm_lock_ctrl with a small parameter
//                set. Stimulus queues per-cycle expectations; a negedge
//                monitor pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mmcm_lock_ctrl;

    localparam int RW = $clog2(2 + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          locked = 1'b0;
    logic          mmcm_rst;
    logic          sys_rst;
    logic          ready;
    logic          fault;
    logic [RW-1:0] retries;
`ifdef MMCM_LOCK_CTRL_RELOCK_CNT_EN
    logic [15:0]   relock_cnt;
`endif

    mmcm_lock_ctrl #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2)
    ) dut (
        .clk_100m   (clk),
        .rst        (rst),
        .locked     (locked),
        .mmcm_rst   (mmcm_rst),
        .sys_rst    (sys_rst),
        .ready      (ready),
        .fault      (fault),
`ifdef MMCM_LOCK_CTRL_RELOCK_CNT_EN
        .relock_cnt (relock_cnt),
`endif
        .retries    (retries)
    );

    always #5 clk = ~clk;

    // Edge counter: after posedge N settles, cyc == N.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int              c;
        logic [4+RW-1:0] v;      // {mmcm_rst, sys_rst, ready, fault, retries}
        logic [15:0]     rlk;
        string           nm;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   base  = 0;
    bit   done  = 1'b0;

    // Expected outputs after edge k of the current run (edge 0 = last rst edge).
    task automatic push(input int k, input bit mr, input bit sr, input bit rdy,
                        input bit flt, input int rt, input int rl, input string nm);
        exp_t e;
        e.c   = base + k;
        e.v   = {mr, sr, rdy, flt, RW'(rt)};
        e.rlk = 16'(rl);
        e.nm  = nm;
        q.push_back(e);
    endtask

    // Hold rst for n edges, release it just after the last one.
    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst  = 1'b0;
        base = cyc;
    endtask

    // Advance to 1 time unit after edge k of the current run.
    task automatic wait_k(input int k);
        while (cyc < base + k) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: compare every expectation whose cycle has arrived.
    always @(negedge clk) begin
        while (q.size() > 0 && (q[0].c <= cyc || done)) begin
            mon_e = q.pop_front();
            n_cmp++;
            if (mon_e.c != cyc) begin
                n_bad++;
                $display("FAIL %s: expectation for cycle %0d not checked in time (now %0d)",
                         mon_e.nm, mon_e.c, cyc);
            end else if ({mmcm_rst, sys_rst, ready, fault, retries} !== mon_e.v) begin
                n_bad++;
                $display("FAIL %s @k=%0d: mr/sr/rdy/flt/ret got %b required %b",
                         mon_e.nm, mon_e.c - base,
                         {mmcm_rst, sys_rst, ready, fault, retries}, mon_e.v);
            end
`ifdef MMCM_LOCK_CTRL_RELOCK_CNT_EN
            if (mon_e.c == cyc) begin
                n_cmp++;
                if (relock_cnt !== mon_e.rlk) begin
                    n_bad++;
                    $display("FAIL %s relock_cnt @k=%0d: got %0d required %0d",
                             mon_e.nm, mon_e.c - base, relock_cnt, mon_e.rlk);
                end
            end
`endif
        end
    end

    initial begin
        // Clean lock: HOLD 4 cycles, WAIT 1, STABLE 8, RUN from edge 13.
        locked = 1'b1;
        do_reset(3);
        for (int k = 0; k <= 15; k++)
            push(k, k <= 3, k < 13, k >= 13, 1'b0, 0, 0, "clean");
        wait_k(16);

        // One-cycle dropout in STABLE: back to WAIT at 9, STABLE again at 10, RUN at 18.
        locked = 1'b1;
        do_reset(2);
        for (int k = 0; k <= 20; k++)
            push(k, k <= 3, k < 18, k >= 18, 1'b0, 0, 0, "glitch");
        wait_k(6);
        locked = 1'b0;
        wait_k(7);
        locked = 1'b1;
        wait_k(21);

        // No lock: timeouts at 24 and 48, FAULT from 48; late lock ignored.
        locked = 1'b0;
        do_reset(2);
        for (int k = 0; k <= 60; k++)
            push(k, (k <= 3) || (k >= 24 && k <= 27) || (k >= 48), 1'b1, 1'b0, k >= 48,
                 (k < 24) ? 0 : ((k < 48) ? 1 : 2), 0, "timeout");
        wait_k(50);
        locked = 1'b1;
        wait_k(61);

        // Lock loss in RUN: drop after edge 15, HOLD at 18.
        locked = 1'b1;
        do_reset(2);
        for (int k = 0; k <= 21; k++)
            push(k, (k <= 3) || (k >= 18), !(k >= 13 && k < 18), (k >= 13 && k < 18),
                 1'b0, 0, (k >= 18) ? 1 : 0, "lockloss");
        wait_k(15);
        locked = 1'b0;
        wait_k(22);

        // Reset pulse while in STABLE, then a full clean sequence.
        locked = 1'b1;
        do_reset(2);
        for (int k = 0; k <= 7; k++)
            push(k, k <= 3, 1'b1, 1'b0, 1'b0, 0, 0, "pre_stable_rst");
        wait_k(7);
        do_reset(1);
        for (int k = 0; k <= 15; k++)
            push(k, k <= 3, k < 13, k >= 13, 1'b0, 0, 0, "rst_in_stable");
        wait_k(16);

        // Reset pulse while in FAULT clears fault and retries.
        locked = 1'b0;
        do_reset(2);
        for (int k = 0; k <= 51; k++)
            push(k, (k <= 3) || (k >= 24 && k <= 27) || (k >= 48), 1'b1, 1'b0, k >= 48,
                 (k < 24) ? 0 : ((k < 48) ? 1 : 2), 0, "pre_fault_rst");
        wait_k(51);
        do_reset(1);
        for (int k = 0; k <= 6; k++)
            push(k, k <= 3, 1'b1, 1'b0, 1'b0, 0, 0, "rst_in_fault");
        wait_k(7);

        // Drain: anything left after the bound is flushed as a failure.
        for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
        done = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mmcm_lock_ctrl.md
Name: mmcm_lock_ctrl

Overview:
- Controller on the other end of the MMCM reset/lock handshake.
- Drives the MMCM's active-high reset and watches its asynchronous lock output.
- Releases a downstream reset only after lock has been stable for a programmable time.
- Re-resets the MMCM on lock timeout or lock loss, and flags a fault after repeated failures.
- Runs in the free-running 100 MHz board clock domain, ahead of the pixel-clock domain.

Parameters:
- RST_CYCLES, 8: cycles mmcm_rst is held high per attempt (≥1).
- LOCK_TIMEOUT, 100000: cycles allowed in WAIT for lock (1 ms at 100 MHz).
- STABLE_CYCLES, 1024: consecutive synchronized-lock cycles required before release.
- MAX_RETRIES, 4: failed attempts before FAULT (≥1).

Ports:
- clk_100m  in  1: 100 MHz free-running clock; sole clock.
- rst  in  1: synchronous, active-high reset.
- locked  in  1: MMCM LOCKED, asynchronous to clk_100m.
- mmcm_rst  out  1: MMCM reset, active high.
- sys_rst  out  1: downstream reset, active high.
- ready  out  1: high only in RUN.
- fault  out  1: high only in FAULT.
- retries  out  $clog2(MAX_RETRIES+1): failed attempts since the last RUN or rst.

Behaviour:
- One clock, clk_100m; reset is synchronous and active-high on rst. All outputs are registered.
- Reset values: state HOLD, mmcm_rst=1, sys_rst=1, ready=0, fault=0, retries=0, all counters 0.
- locked passes through a 2-flop synchronizer to give locked_s; 2 cycles latency. FSM uses locked_s only.
- Outputs decode from the state register and change on the same edge as the state.
  - mmcm_rst=1 in HOLD and FAULT.
  - sys_rst=0 only in RUN.
- HOLD:
  - Counter runs 0..RST_CYCLES-1.
  - At the terminal count: enter WAIT and clear the timer.
- WAIT (mmcm_rst=0):
  - Timer increments every cycle.
  - locked_s=1: enter STABLE with the stable counter cleared. This takes priority over timeout in the same cycle.
  - Timer reaches LOCK_TIMEOUT-1 with locked_s=0: fail.
- STABLE:
  - Stable counter increments while locked_s=1.
  - locked_s=0: return to WAIT with the timer cleared. This is a glitch and is not a failure.
  - Counter reaches STABLE_CYCLES-1 with locked_s=1: enter RUN and clear retries.
- RUN:
  - Stays while locked_s=1.
  - locked_s=0: enter HOLD. This is a lock-loss relock; it does not increment retries.
- Fail action:
  - If retries==MAX_RETRIES-1: retries saturates at MAX_RETRIES and state goes to FAULT.
  - Otherwise retries+1 and state goes to HOLD.
- FAULT: terminal until rst; mmcm_rst=1, sys_rst=1, locked ignored.
- rst mid-operation: on the next edge, return to reset values regardless of state. mmcm_rst stays high, so there is no glitch.
- Counters sized $clog2 of their limit and never wrap; they are cleared on every state entry.

Optional Feature:
- Macro: MMCM_LOCK_CTRL_RELOCK_CNT_EN.
- When defined:
  - Adds output relock_cnt [15:0], reset 0.
  - Increments on each RUN→HOLD transition and saturates at 16'hFFFF.
  - Not cleared by reaching RUN; only rst clears it.
- When undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package mmcm_lock_pkg holds the state enum typedef lock_state_t {HOLD, WAIT, STABLE, RUN, FAULT}. Width is 3 bits, explicitly sized.
- Sub-module sync_2ff: 2-flop synchronizer with parameterized width and reset value 0. Reusable for other async status inputs.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2):
- Clean lock: locked=1 constant, rst released at edge 0.
  - mmcm_rst high edges 0–3, low from edge 4.
  - ready=1 and sys_rst=0 from edge 13.
  - retries=0.
- Glitch in STABLE: locked pulses low 1 cycle during STABLE.
  - FSM returns to WAIT, then re-enters STABLE.
  - ready delayed by the full 8-cycle restart.
  - retries stays 0.
- Timeout and fault: locked=0 throughout.
  - Two 4-cycle mmcm_rst pulses separated by 20-cycle WAITs.
  - retries goes 1 then 2; fault=1 after the second timeout.
  - mmcm_rst stays high; later locked=1 has no effect.
- Lock loss in RUN: drop locked after ready.
  - ready falls and mmcm_rst rises 3 edges after the drop (2 sync + 1 FSM).
  - retries unchanged.
  - With the macro defined, relock_cnt=1.
- Mid-operation reset: assert rst 1 cycle during STABLE and during FAULT.
  - Next edge: mmcm_rst=1, sys_rst=1, fault=0, retries=0.
  - Sequence restarts from HOLD.
